// File: rtl/hash_arb.sv
// hash_arb: round-robin arbiter sharing one XOR-fold hash stage; optional HASH_ARB_STATS_EN adds grant/stall counters
module hash_arb #(
   parameter int NUM_REQ   = 4,
   parameter int IN_WIDTH  = 40,
   parameter int OUT_WIDTH = 8,
   localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid_RnnH,
   input  logic [NUM_REQ*IN_WIDTH-1:0]  req_key_RnnH,
   output logic [NUM_REQ-1:0]           req_ready_RnnH,
   input  logic                         cfg_we_RnnH,
   input  logic [OUT_WIDTH-1:0]         cfg_mask_RnnH,
   output logic                         out_valid_RnnH,
   output logic [OUT_WIDTH-1:0]         out_hash_RnnH,
   output logic [IDW-1:0]               out_id_RnnH,
`ifdef HASH_ARB_STATS_EN
   output logic [NUM_REQ*16-1:0]        stat_grants_RnnH,
   output logic [15:0]                  stat_stall_RnnH,
`endif
   input  logic                         out_ready_RnnH
);

   logic [IDW-1:0]       ptr;
   logic [IDW-1:0]       gnt_id;
   logic [IDW-1:0]       idx;
   logic                 found;
   logic                 grant;
   logic                 stage_free;
   logic [IN_WIDTH-1:0]  sel_key;
   logic [OUT_WIDTH-1:0] mask_q;
   logic [OUT_WIDTH-1:0] hash;

   assign stage_free = !out_valid_RnnH | out_ready_RnnH;

   // round-robin search from ptr upward with wrap; first valid requester wins
   always_comb begin
      found   = 1'b0;
      gnt_id  = '0;
      idx     = '0;
      sel_key = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NUM_REQ);
         if (!found && req_valid_RnnH[idx]) begin
            found   = 1'b1;
            gnt_id  = idx;
            sel_key = req_key_RnnH[int'(idx)*IN_WIDTH +: IN_WIDTH];
         end
      end
   end

   assign grant          = found && stage_free && !rst;
   assign req_ready_RnnH = grant ? (NUM_REQ'(1) << gnt_id) : '0;

   // the two overlapping 32-bit folds cancel their middle bytes, leaving the outer bytes
   assign hash = (sel_key[7:0] ^ sel_key[39:32]) & mask_q;

   // active mask; a same-cycle grant still sees the old value
   always_ff @(posedge clk) begin
      if (rst)
         mask_q <= '1;
      else if (cfg_we_RnnH)
         mask_q <= cfg_mask_RnnH;
   end

   // rotate priority to just past the last winner
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (grant)
         ptr <= (gnt_id == IDW'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
   end

   // single output register: load on grant, drain when accepted with nothing new
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_RnnH <= 1'b0;
         out_hash_RnnH  <= '0;
         out_id_RnnH    <= '0;
      end else if (grant) begin
         out_valid_RnnH <= 1'b1;
         out_hash_RnnH  <= hash;
         out_id_RnnH    <= gnt_id;
      end else if (out_ready_RnnH) begin
         out_valid_RnnH <= 1'b0;
      end
   end

`ifdef HASH_ARB_STATS_EN
   logic [15:0] grant_cnt [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      // saturating per-requester grant count
      always_ff @(posedge clk) begin
         if (rst)
            grant_cnt[g] <= '0;
         else if (req_ready_RnnH[g] && grant_cnt[g] != 16'hFFFF)
            grant_cnt[g] <= grant_cnt[g] + 16'd1;
      end
      assign stat_grants_RnnH[g*16 +: 16] = grant_cnt[g];
   end

   // saturating count of cycles the downstream holds back a valid result
   always_ff @(posedge clk) begin
      if (rst)
         stat_stall_RnnH <= '0;
      else if (out_valid_RnnH && !out_ready_RnnH && stat_stall_RnnH != 16'hFFFF)
         stat_stall_RnnH <= stat_stall_RnnH + 16'd1;
   end
`endif

endmodule

// File: tb/tb_hash_arb.sv
// tb_hash_arb: directed self-checking bench for hash_arb
module tb_hash_arb;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [159:0] req_key;
   logic [3:0]   req_ready;
   logic         cfg_we;
   logic [7:0]   cfg_mask;
   logic         out_valid;
   logic [7:0]   out_hash;
   logic [1:0]   out_id;
   logic         out_ready;
`ifdef HASH_ARB_STATS_EN
   logic [63:0]  stat_grants;
   logic [15:0]  stat_stall;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   hash_arb dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid_RnnH (req_valid),
      .req_key_RnnH   (req_key),
      .req_ready_RnnH (req_ready),
      .cfg_we_RnnH    (cfg_we),
      .cfg_mask_RnnH  (cfg_mask),
      .out_valid_RnnH (out_valid),
      .out_hash_RnnH  (out_hash),
      .out_id_RnnH    (out_id),
`ifdef HASH_ARB_STATS_EN
      .stat_grants_RnnH (stat_grants),
      .stat_stall_RnnH  (stat_stall),
`endif
      .out_ready_RnnH (out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rr_hash [4] = '{8'h30, 8'h21, 8'h12, 8'h03};
   int         rr_id   [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst       = 1'b1;
      req_valid = 4'hF;
      cfg_we    = 1'b0;
      cfg_mask  = 8'h00;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++)
         req_key[i*40 +: 40] = {8'h30, 24'h0, 8'(i * 8'h11)};
      tick;
      tick;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_hash", 32'(out_hash), 32'h0);
      chk("rst_id", 32'(out_id), 32'h0);
`ifdef HASH_ARB_STATS_EN
      chk("rst_stall", 32'(stat_stall), 32'h0);
`endif
      rst = 1'b0;
      #1;
      for (int g = 0; g < 5; g++) begin
         chk($sformatf("rr_ready%0d", g), 32'(req_ready), 32'(4'b1 << rr_id[g]));
         tick;
         chk($sformatf("rr_valid%0d", g), 32'(out_valid), 32'h1);
         chk($sformatf("rr_id%0d", g), 32'(out_id), 32'(rr_id[g]));
         chk($sformatf("rr_hash%0d", g), 32'(out_hash), 32'(rr_hash[rr_id[g]]));
      end
      req_valid = 4'h0;
      #1;
      chk("idle_ready", 32'(req_ready), 32'h0);
      tick;
      chk("drain_valid", 32'(out_valid), 32'h0);

      req_key[80 +: 40] = 40'h11_2233_4455;
      req_valid = 4'b0100;
      #1;
      chk("k2_ready", 32'(req_ready), 32'h4);
      tick;
      chk("k2_hash", 32'(out_hash), 32'h44);
      chk("k2_id", 32'(out_id), 32'h2);
      chk("k2_valid", 32'(out_valid), 32'h1);

      req_valid = 4'b0001;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("stall_ready%0d", c), 32'(req_ready), 32'h0);
         tick;
         chk($sformatf("stall_hash%0d", c), 32'(out_hash), 32'h44);
         chk($sformatf("stall_id%0d", c), 32'(out_id), 32'h2);
         chk($sformatf("stall_valid%0d", c), 32'(out_valid), 32'h1);
      end
`ifdef HASH_ARB_STATS_EN
      chk("stall_cnt", 32'(stat_stall), 32'h3);
`endif
      out_ready = 1'b1;
      #1;
      chk("wrap_ready", 32'(req_ready), 32'h1);
      tick;
      chk("wrap_id", 32'(out_id), 32'h0);
      chk("wrap_hash", 32'(out_hash), 32'h30);

      req_key[40 +: 40] = 40'hF0_0000_000F;
      req_valid = 4'b0010;
      cfg_we    = 1'b1;
      cfg_mask  = 8'h0F;
      #1;
      chk("mask_ready", 32'(req_ready), 32'h2);
      tick;
      cfg_we = 1'b0;
      chk("mask_old", 32'(out_hash), 32'hFF);
      chk("mask_old_id", 32'(out_id), 32'h1);
      #1;
      chk("mask2_ready", 32'(req_ready), 32'h2);
      tick;
      chk("mask_new", 32'(out_hash), 32'h0F);

      req_valid = 4'b1010;
      rst = 1'b1;
      #1;
      chk("rst2_ready", 32'(req_ready), 32'h0);
      tick;
      chk("rst2_valid", 32'(out_valid), 32'h0);
      chk("rst2_hash", 32'(out_hash), 32'h0);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(req_ready), 32'h2);
      tick;
      chk("post_rst_id", 32'(out_id), 32'h1);
      chk("post_rst_hash", 32'(out_hash), 32'hFF);
      #1;
      chk("post_rst_next", 32'(req_ready), 32'h8);
`ifdef HASH_ARB_STATS_EN
      chk("post_rst_stall", 32'(stat_stall), 32'h0);
      chk("post_rst_g1", 32'(stat_grants[16 +: 16]), 32'h1);
      req_valid = 4'b0010;
      repeat (70000) tick;
      chk("sat_g1", 32'(stat_grants[16 +: 16]), 32'hFFFF);
      chk("sat_g0", 32'(stat_grants[0 +: 16]), 32'h0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hash_arb.md
HASH_ARB -- requirements
Module: hash_arb

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, number of requesters sharing the hash datapath (2..8).
REQ-002 The module SHALL have parameter IN_WIDTH, default 40, width of each request key (fixed at 40).
REQ-003 The module SHALL have parameter OUT_WIDTH, default 8, width of the hashed result (fixed at 8).
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 The module SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 The module SHALL have port req_valid_RnnH, input, NUM_REQ, per-requester key valid.
REQ-007 The module SHALL have port req_key_RnnH, input, NUM_REQ*IN_WIDTH, packed keys; requester i occupies bits [i*IN_WIDTH +: IN_WIDTH].
REQ-008 The module SHALL have port req_ready_RnnH, output, NUM_REQ, one-hot grant/accept.
REQ-009 The module SHALL have port cfg_we_RnnH, input, 1, mask write strobe.
REQ-010 The module SHALL have port cfg_mask_RnnH, input, OUT_WIDTH, new hash mask.
REQ-011 The module SHALL have port out_valid_RnnH, output, 1, result valid.
REQ-012 The module SHALL have port out_hash_RnnH, output, OUT_WIDTH, masked hash.
REQ-013 The module SHALL have port out_id_RnnH, output, $clog2(NUM_REQ), id of the requester the result belongs to.
REQ-014 The module SHALL have port out_ready_RnnH, input, 1, downstream accept.

Function
REQ-015 The hash SHALL be (key[7:0] ^ key[15:8] ^ key[23:16] ^ key[31:24]) ^ (key[15:8] ^ key[23:16] ^ key[31:24] ^ key[39:32]), which reduces to key[7:0] ^ key[39:32], ANDed with the active mask.
REQ-016 The output stage SHALL be a single register; stage_free = !out_valid_RnnH | out_ready_RnnH.
REQ-017 When stage_free is high and any req_valid is set, exactly one req_ready bit SHALL assert, chosen round-robin; otherwise all req_ready bits SHALL be 0.
REQ-018 Round-robin SHALL search from pointer ptr upward with wrap; after a grant to i, ptr SHALL become (i+1) mod NUM_REQ; ptr SHALL be unchanged without a grant.
REQ-019 req_ready SHALL depend combinationally on req_valid, ptr, out_valid and out_ready only, never on key or mask.
REQ-020 On a grant the output register SHALL load hash, id and out_valid=1 on the next edge (latency 1 cycle).
REQ-021 When out_valid=1 and out_ready=0, out_hash and out_id SHALL hold stable and no grant SHALL occur.
REQ-022 When out_ready=1 and no request is valid, out_valid SHALL clear on the next edge.
REQ-023 Back-to-back results SHALL be sustained at 1 per cycle while out_ready stays high.
REQ-024 cfg_we SHALL update the active mask on the next edge; a key granted in the same cycle as cfg_we SHALL use the old mask.
REQ-025 A result already in the output register SHALL keep its hash when the mask changes.

Reset
REQ-026 rst SHALL set out_valid=0, out_hash=0, out_id=0, ptr=0, and active mask to all ones (8'hFF).
REQ-027 While rst is high, req_ready SHALL be all 0; an in-flight result SHALL be discarded, not delivered.
REQ-028 In the first cycle after rst deasserts, grants SHALL be allowed, with priority starting at requester 0.

Configuration
REQ-029 With macro HASH_ARB_STATS_EN defined, the module SHALL add output stat_grants_RnnH (NUM_REQ*16), a saturating 16-bit grant count per requester, and output stat_stall_RnnH (16), a saturating count of cycles with out_valid=1 and out_ready=0; all of these SHALL clear on rst.
REQ-030 Without HASH_ARB_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover: after reset, all 4 req_valid high, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, and out_id follows one cycle later.
REQ-032 The bench SHALL cover: key 40'h11_2233_4455 from requester 2, mask FF -> out_hash=8'h44 (0x55^0x11), out_id=2, one cycle after grant.
REQ-033 The bench SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> req_ready=0, outputs stable; with HASH_ARB_STATS_EN, stat_stall=3.
REQ-034 The bench SHALL cover: cfg_we with mask 8'h0F in the same cycle as the grant of key 40'hF0_0000_000F -> out_hash=8'hFF; next identical key -> 8'h0F.
REQ-035 The bench SHALL cover: rst asserted while out_valid=1 -> out_valid=0 on the next edge, ptr=0, and the first post-reset grant goes to the lowest valid requester.
REQ-036 The bench SHALL cover: requester 1 alone valid for 70000 grants with HASH_ARB_STATS_EN -> stat_grants[1] saturates at 16'hFFFF.
